// File: rtl/alu.sv
// alu: n-bit arithmetic/logic execute stage with one cycle of latency.
// A 3-bit opcode picks one of eight operations on the unsigned operands a and b.
// The n-bit result and a carry/borrow/shift-out flag are both registered.
// An unknown or unmatched opcode yields a registered zero, so X on sel never escapes.
module alu #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [2:0]   sel,
    output logic [n-1:0] s,
    output logic         co
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_INC = 3'd7;

    // Operands widened by one bit so that the top bit of every result is the flag.
    logic [n:0]   w_a_ext;
    logic [n:0]   w_b_ext;
    logic [n:0]   w_one_ext;
    logic [n:0]   w_res;
    logic [n-1:0] r_s;
    logic         r_co;

    assign w_a_ext   = {1'b0, a};
    assign w_b_ext   = {1'b0, b};
    assign w_one_ext = {{n{1'b0}}, 1'b1};

    // Next-state result {flag, value}. Subtraction modulo 2^(n+1) leaves the
    // borrow in the top bit. A shift left exposes a[n-1] as the flag, and a shift
    // right exposes a[0].
    always_comb begin
        w_res = '0;
        case (sel)
            OP_ADD:  w_res = w_a_ext + w_b_ext;
            OP_SUB:  w_res = w_a_ext - w_b_ext;
            OP_AND:  w_res = {1'b0, a & b};
            OP_OR:   w_res = {1'b0, a | b};
            OP_XOR:  w_res = {1'b0, a ^ b};
            OP_SHL:  w_res = {a, 1'b0};
            OP_SHR:  w_res = {a[0], 1'b0, a[n-1:1]};
            OP_INC:  w_res = w_a_ext + w_one_ext;
            default: w_res = '0;
        endcase
    end

    // Output register. An asynchronous reset drops any result that is still pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s  <= '0;
            r_co <= 1'b0;
        end else begin
            r_s  <= w_res[n-1:0];
            r_co <= w_res[n];
        end
    end

    assign s  = r_s;
    assign co = r_co;

endmodule

// File: tb/tb_alu.sv
// tb_alu: checks alu against an arithmetic reference model on every cycle,
// plus literal spot checks on the boundary cases.
module tb_alu;

    localparam int N = 4;
    localparam int M = 1 << N;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] a   = '0;
    logic [N-1:0] b   = '0;
    logic [2:0]   sel = '0;
    logic [N-1:0] s;
    logic         co;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [N-1:0] exp_s  = '0;
    logic         exp_co = 1'b0;

    always #5 clk = ~clk;

    alu #(.n(N)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .sel (sel),
        .s   (s),
        .co  (co)
    );

    // Reference model: {co,s} as an integer in the range 0 .. 2M-1.
    function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic [2:0] op);
        int xa;
        int ya;
        int r;
        if ($isunknown(op)) return '0;
        xa = int'(x);
        ya = int'(y);
        case (int'(op))
            0: r = xa + ya;
            1: r = (xa < ya) ? (2 * M + xa - ya) : (xa - ya);
            2: r = xa & ya;
            3: r = xa | ya;
            4: r = xa ^ ya;
            5: r = xa * 2;
            6: r = (xa % 2) * M + xa / 2;
            7: r = xa + 1;
            default: r = 0;
        endcase
        return (N+1)'(r);
    endfunction

    // The expected output tracks the inputs seen at each edge and clears on reset.
    always @(posedge clk or posedge rst) begin
        if (rst) {exp_co, exp_s} <= '0;
        else     {exp_co, exp_s} <= model(a, b, sel);
    end

    task automatic check(input string nm, input logic [N-1:0] es, input logic ec);
        n_cmp++;
        if (s !== es || co !== ec) begin
            n_bad++;
            $display("FAIL %s: got s=%b co=%b, want s=%b co=%b (t=%0t)", nm, s, co, es, ec, $time);
        end
    endtask

    // Compare the DUT with the model at every falling edge.
    always @(negedge clk) begin
        if (chk_en) check("model", exp_s, exp_co);
    end

    task automatic apply(input logic [N-1:0] x, input logic [N-1:0] y, input logic [2:0] op);
        @(posedge clk);
        #2;
        a   = x;
        b   = y;
        sel = op;
    endtask

    task automatic lit(input string nm, input logic [N-1:0] es, input logic ec);
        @(posedge clk);
        #3;
        check(nm, es, ec);
    endtask

    initial begin
        logic [2:0] sel_x;
        sel_x = 3'b11x;

        // Asynchronous reset, applied before any clock edge.
        a = 4'b1111; b = 4'b1111; sel = 3'd0;
        #2 rst = 1'b1;
        #1 check("rst_async", 4'b0000, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;
        lit("rst_release_add", 4'b1110, 1'b1);

        // Sweep the diagonal with ADD and SUB.
        for (int i = 0; i < M; i++) begin
            apply(N'(i), N'(i), 3'd0);
            lit("add_diag", N'((2 * i) % M), (i >= M / 2));
        end
        apply(4'b0111, 4'b0111, 3'd0);
        lit("add_0111", 4'b1110, 1'b0);
        for (int i = 0; i < M; i++) begin
            apply(N'(i), N'(i), 3'd1);
            lit("sub_diag", 4'b0000, 1'b0);
        end
        apply(4'b0000, 4'b0001, 3'd1);
        lit("sub_borrow", 4'b1111, 1'b1);

        // Logic operations.
        apply(4'b1010, 4'b1010, 3'd2); lit("and_diag", 4'b1010, 1'b0);
        apply(4'b1010, 4'b1010, 3'd3); lit("or_diag",  4'b1010, 1'b0);
        apply(4'b1010, 4'b1010, 3'd4); lit("xor_diag", 4'b0000, 1'b0);
        apply(4'b1100, 4'b1010, 3'd2); lit("and_mix",  4'b1000, 1'b0);
        apply(4'b1100, 4'b1010, 3'd3); lit("or_mix",   4'b1110, 1'b0);
        apply(4'b1100, 4'b1010, 3'd4); lit("xor_mix",  4'b0110, 1'b0);

        // Shifts and increment.
        apply(4'b1001, 4'b0110, 3'd5); lit("shl", 4'b0010, 1'b1);
        apply(4'b1001, 4'b0110, 3'd6); lit("shr", 4'b0100, 1'b1);
        apply(4'b1111, 4'b0000, 3'd7); lit("inc_wrap", 4'b0000, 1'b1);
        apply(4'b0110, 4'b1111, 3'd7); lit("inc", 4'b0111, 1'b0);
        apply(4'b1111, 4'b1111, 3'd1); lit("sub_eq_ones", 4'b0000, 1'b0);

        // Unknown opcode; the simulator may collapse it to a known value.
        apply(4'b1111, 4'b1111, sel_x);
        @(posedge clk);
        #3;
        if ($isunknown(sel)) check("sel_unknown", 4'b0000, 1'b0);
        apply(4'b1111, 4'b1111, 3'd7);
        lit("after_unknown", 4'b0000, 1'b1);

        // Step through every opcode, then pulse reset between edges.
        for (int i = 0; i < 8; i++) apply(N'($urandom), N'($urandom), 3'(i));
        apply(4'b1001, 4'b0011, 3'd5);
        rst = 1'b1;
        #1 check("mid_rst", 4'b0000, 1'b0);
        #1 rst = 1'b0;
        lit("post_rst", 4'b0010, 1'b1);

        // Random stimulus, checked against the model on every cycle.
        for (int i = 0; i < 400; i++) apply(N'($urandom), N'($urandom), 3'($urandom_range(0, 7)));

        @(posedge clk);
        #3;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
